// File: rtl/uart_tx_controller_if.sv
// rtl/uart_tx_controller_if.sv - word handshake between the UART transmitter's producer and frame sequencer
interface uart_tx_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  data_ready;
    logic                  par_en;
    logic                  par_type;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_type,
        input  data_ready
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_type,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - UART transmit frame sequencer: bit timing, serializer stepping, line mux
module uart_tx_controller #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int CLKS_PER_BIT = 16,
    parameter  int STOP_BITS    = 1,
    localparam int IDX_W        = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_tx_controller_if.slave   up_if,
    output logic [DATA_WIDTH-1:0] ser_parallel,
    output logic                  ser_en,
    output logic [IDX_W-1:0]      ser_data_index,
    input  logic                  ser_data,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [TICK_W-1:0]  tick_cnt;
    logic [IDX_W-1:0]   bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic               par_bit_q;
    logic               par_en_q;
    logic               last_tick;
    logic               accept;

    assign last_tick     = (tick_cnt == TICK_W'(CLKS_PER_BIT - 1));
    assign up_if.data_ready = (state == IDLE);
    assign accept        = up_if.data_valid & up_if.data_ready;
    assign busy          = (state != IDLE);
    assign ser_parallel  = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            if (state == IDLE || last_tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            // Word and parity are frozen at accept so upstream may move on immediately.
            if (accept) begin
                data_q    <= up_if.p_data;
                par_en_q  <= up_if.par_en;
                par_bit_q <= (^up_if.p_data) ^ up_if.par_type;
            end
        end
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        ser_en         = 1'b0;
        ser_data_index = '0;
        tx_out         = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                tx_out = 1'b0;
                if (last_tick) begin
                    ser_en     = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_out = ser_data;
                if (last_tick) begin
                    if (bit_cnt != IDX_W'(DATA_WIDTH - 1)) begin
                        // Serializer output is registered, so request the next bit one edge early.
                        ser_en         = 1'b1;
                        ser_data_index = bit_cnt + IDX_W'(1);
                        bit_cnt_next   = bit_cnt + IDX_W'(1);
                    end else begin
                        bit_cnt_next = '0;
                        state_next   = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tx_out = par_bit_q;
                if (last_tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                tx_out = 1'b1;
                if (last_tick) begin
                    if (bit_cnt == IDX_W'(STOP_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - directed table-driven bench for uart_tx_controller with serializer model
module tb_uart_tx_controller;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] ser_parallel;
    logic          ser_en;
    logic [2:0]    ser_data_index;
    logic          ser_data;
    logic          tx_out;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_controller_if #(.DATA_WIDTH(DW)) u_if ();

    uart_tx_controller #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .up_if         (u_if.slave),
        .ser_parallel  (ser_parallel),
        .ser_en        (ser_en),
        .ser_data_index(ser_data_index),
        .ser_data      (ser_data),
        .tx_out        (tx_out),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered serializer, as attached in the real transmitter.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ser_data <= 1'b0;
        else if (ser_en) ser_data <= ser_parallel[ser_data_index];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       exp_par;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];
    int   accept_cyc;
    int   prev_accept;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                             input logic exp_par, input int exp_busy,
                             input logic hold, input logic [7:0] next_d);
        logic [11:0] line;
        int nbits, n, pulses, idx_err, busy_cnt, got;
        nbits = exp_busy / CPB;
        line  = pe ? {1'b1, 1'b1, exp_par, d, 1'b0} : {2'b11, 1'b1, d, 1'b0};
        u_if.p_data = d; u_if.par_en = pe; u_if.par_type = pt; u_if.data_valid = 1'b1;
        n = 0;
        while (!u_if.data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready before accept"}, int'(u_if.data_ready), 1);
        accept_cyc = cyc;
        @(posedge clk);
        pulses = 0; idx_err = 0; busy_cnt = 0;
        for (int b = 0; b < nbits; b++) begin
            got = int'(line[b]);
            for (int t = 0; t < CPB; t++) begin
                @(negedge clk);
                if (b == 0 && t == 0) begin
                    chk({tag, " ser_parallel"}, int'(ser_parallel), int'(d));
                    if (hold) u_if.p_data = next_d;
                    else begin
                        u_if.data_valid = 1'b0; u_if.p_data = ~d;
                        u_if.par_type = ~pt;    u_if.par_en = ~pe;
                    end
                end
                if (tx_out !== line[b]) got = int'(tx_out);
                if (busy) busy_cnt++;
                if (ser_en) begin
                    if (int'(ser_data_index) != pulses) idx_err++;
                    pulses++;
                end else if (ser_data_index != 3'd0) idx_err++;
            end
            chk($sformatf("%s tx_out bit%0d", tag, b), got, int'(line[b]));
        end
        chk({tag, " ser_en pulses"}, pulses, DW);
        chk({tag, " ser_data_index errors"}, idx_err, 0);
        chk({tag, " busy cycles"}, busy_cnt, exp_busy);
        @(negedge clk);
        chk({tag, " busy after frame"}, int'(busy), 0);
        chk({tag, " tx_out after frame"}, int'(tx_out), 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 44};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 44};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 40};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 44};
        vecs[4] = '{8'h7F, 1'b1, 1'b1, 1'b0, 44};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b0, 40};

        reset_n = 1'b0;
        u_if.p_data = 8'h00; u_if.data_valid = 1'b0; u_if.par_en = 1'b0; u_if.par_type = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_out", int'(tx_out), 1);
        chk("reset data_ready", int'(u_if.data_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset ser_en", int'(ser_en), 0);
        chk("reset ser_data_index", int'(ser_data_index), 0);
        chk("reset ser_parallel", int'(ser_parallel), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pe, vecs[i].pt,
                      vecs[i].exp_par, vecs[i].exp_busy, 1'b0, 8'h00);
            @(negedge clk);
        end

        // data_valid held high across two frames: accepts are 41 cycles apart.
        run_frame("b2b0", 8'h00, 1'b0, 1'b0, 1'b0, 40, 1'b1, 8'hFF);
        prev_accept = accept_cyc;
        run_frame("b2b1", 8'hFF, 1'b0, 1'b0, 1'b0, 40, 1'b0, 8'h00);
        chk("b2b accept spacing", accept_cyc - prev_accept, 41);
        @(negedge clk);

        // Reset during data bit 3 of 0x3C, then a clean 0x81 frame.
        u_if.p_data = 8'h3C; u_if.par_en = 1'b1; u_if.par_type = 1'b0; u_if.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.data_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("abort busy before reset", int'(busy), 1);
        chk("abort tx_out bit3", int'(tx_out), 1);
        reset_n = 1'b0;
        #1;
        chk("abort busy at reset", int'(busy), 0);
        chk("abort tx_out at reset", int'(tx_out), 1);
        chk("abort ready at reset", int'(u_if.data_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_frame("post_reset", 8'h81, 1'b0, 1'b0, 1'b0, 40, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
